// File: rtl/fpu_stim_seq.sv
// Operand sequencer for one FPU: issues LFSR-generated operand pairs over a start/ready
// handshake and folds results into a rotating signature with sticky exception flags.
module fpu_stim_seq #(
    parameter int          DATA_W  = 32,
    parameter int          CNT_W   = 16,
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] SEED_A  = 32'h00000001,
    parameter logic [31:0] SEED_B  = 32'h12345678,
    parameter logic [31:0] TAPS    = 32'h80200003
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start_i,
    input  logic [CNT_W-1:0]  cfg_num_ops_i,
    input  logic [2:0]        cfg_op_i,
    input  logic              cfg_cycle_ops_i,
    input  logic [1:0]        cfg_rmode_i,
    output logic [DATA_W-1:0] fpu_opa_o,
    output logic [DATA_W-1:0] fpu_opb_o,
    output logic [2:0]        fpu_op_o,
    output logic [1:0]        fpu_rmode_o,
    output logic              fpu_start_o,
    input  logic              fpu_ready_i,
    input  logic [DATA_W-1:0] fpu_result_i,
    input  logic [7:0]        fpu_exc_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  issued_cnt_o,
    output logic [7:0]        exc_sticky_o,
    output logic [DATA_W-1:0] sig_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] TAPS_D   = DATA_W'(TAPS);
    localparam logic [DATA_W-1:0] SEED_A_D = DATA_W'(SEED_A);
    localparam logic [DATA_W-1:0] SEED_B_D = DATA_W'(SEED_B);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_ops_q;
    logic [2:0]        op_q;
    logic              cycle_q;
    logic [1:0]        rmode_q;
    logic [DATA_W-1:0] lfsr_a_q, lfsr_b_q;
    logic [TW-1:0]     timer_q;
    logic              start_run, accept, last_op, expire;
    logic [DATA_W-1:0] lfsr_a_nx, lfsr_b_nx;
    logic [2:0]        op_nx;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS_D : '0);
    endfunction

    assign lfsr_a_nx = lfsr_step(lfsr_a_q);
    assign lfsr_b_nx = lfsr_step(lfsr_b_q);
    assign op_nx     = cycle_q ? op_q + 3'd1 : op_q;

    // Handshake: fpu_start_o is high for exactly the ISSUE cycle with operands valid;
    // fpu_ready_i/result/exc are sampled only in WAIT and ignored in every other state.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        accept    = 1'b0;
        last_op   = 1'b0;
        expire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start_i) begin
                    start_run = 1'b1;
                    state_d   = (cfg_num_ops_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (fpu_ready_i) begin
                    accept  = 1'b1;
                    last_op = (issued_cnt_o + CNT_W'(1)) == num_ops_q;
                    state_d = last_op ? S_DONE : S_ISSUE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    expire  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign fpu_start_o = (state_q == S_ISSUE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            num_ops_q    <= '0;
            op_q         <= '0;
            cycle_q      <= 1'b0;
            rmode_q      <= '0;
            lfsr_a_q     <= SEED_A_D;
            lfsr_b_q     <= SEED_B_D;
            timer_q      <= '0;
            fpu_opa_o    <= '0;
            fpu_opb_o    <= '0;
            fpu_op_o     <= '0;
            fpu_rmode_o  <= '0;
            timeout_o    <= 1'b0;
            issued_cnt_o <= '0;
            exc_sticky_o <= '0;
            sig_o        <= '0;
        end else begin
            if (state_q == S_ISSUE)     timer_q <= '0;
            else if (state_q == S_WAIT) timer_q <= timer_q + TW'(1);

            if (start_run) begin
                num_ops_q    <= cfg_num_ops_i;
                op_q         <= cfg_op_i;
                cycle_q      <= cfg_cycle_ops_i;
                rmode_q      <= cfg_rmode_i;
                lfsr_a_q     <= SEED_A_D;
                lfsr_b_q     <= SEED_B_D;
                issued_cnt_o <= '0;
                exc_sticky_o <= '0;
                sig_o        <= '0;
                timeout_o    <= 1'b0;
                // Operand outputs only move when an ISSUE follows, so an empty run keeps them.
                if (cfg_num_ops_i != '0) begin
                    fpu_opa_o   <= SEED_A_D;
                    fpu_opb_o   <= SEED_B_D;
                    fpu_op_o    <= cfg_op_i;
                    fpu_rmode_o <= cfg_rmode_i;
                end
            end

            if (accept) begin
                sig_o        <= {sig_o[DATA_W-2:0], sig_o[DATA_W-1]} ^ fpu_result_i;
                exc_sticky_o <= exc_sticky_o | fpu_exc_i;
                issued_cnt_o <= issued_cnt_o + CNT_W'(1);
                if (!last_op) begin
                    lfsr_a_q    <= lfsr_a_nx;
                    lfsr_b_q    <= lfsr_b_nx;
                    op_q        <= op_nx;
                    fpu_opa_o   <= lfsr_a_nx;
                    fpu_opb_o   <= lfsr_b_nx;
                    fpu_op_o    <= op_nx;
                    fpu_rmode_o <= rmode_q;
                end
            end

            if (expire) timeout_o <= 1'b1;
        end
    end
endmodule
